// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall handling and the IF/ID
// slot that holds the fetched instruction steady across hazard stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        is_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        flush_id
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] hold_inst_q;
  logic        started_q;
  logic        valid_q;
  logic        stall_dly_q;

  always_comb begin
    pc_next = pc_q + 32'd4;
    if (is_branch) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (stall || !started_q) begin
      pc_next = pc_q;
    end
  end

  assign imem_addr = pc_next;
  assign imem_en   = is_branch | ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      started_q   <= 1'b0;
      valid_q     <= 1'b0;
      stall_dly_q <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      pc_q        <= pc_next;
      started_q   <= 1'b1;
      // The first edge out of reset already latches mem[RESET_PC], so the
      // slot it produces is a real instruction; valid stays set from then on.
      valid_q     <= 1'b1;
      stall_dly_q <= stall & ~is_branch;
      if (stall && !stall_dly_q && !is_branch) begin
        hold_inst_q <= imem_rdata;
      end
    end
  end

  assign id_inst  = stall_dly_q ? hold_inst_q : imem_rdata;
  assign id_pc    = pc_q;
  assign id_pc4   = pc_q + 32'd4;
  assign id_valid = valid_q & ~is_branch;
  assign flush_id = is_branch;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous-read instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        is_branch;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        flush_id;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
    .id_valid(id_valid), .flush_id(flush_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Unread cycles return garbage so a design that trusts them is caught.
  always @(posedge clk) imem_rdata <= imem_en ? mem_f(imem_addr) : 32'hDEADBEEF;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; is_branch = 1'b0; branch_target = '0;
    tick; tick; #2;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    tick; rst_n = 1'b1; #2;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b want 0", id_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL c1_addr: got %h want 0", imem_addr); end
    tick; #2;
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL c2_pc: got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL c2_inst: got %h want 13", id_inst); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL c2_valid: got %b want 1", id_valid); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL c2_addr: got %h want 4", imem_addr); end
    checks++; if (id_pc4 !== 32'h4) begin errors++; $display("FAIL c2_pc4: got %h want 4", id_pc4); end
    tick; #2;
    checks++; if (id_pc !== 32'h4 || id_inst !== mem_f(32'h4)) begin errors++; $display("FAIL c3_seq: got pc=%h inst=%h want pc=4 inst=%h", id_pc, id_inst, mem_f(32'h4)); end
  endtask

  task automatic test_branch;
    is_branch = 1'b1; branch_target = 32'h10;
    tick; is_branch = 1'b0; #2;
    checks++; if (id_pc !== 32'h10 || id_valid !== 1'b1) begin errors++; $display("FAIL br_setup: got pc=%h v=%b want pc=10 v=1", id_pc, id_valid); end
    is_branch = 1'b1; branch_target = 32'h40; #2;
    checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush_id); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", id_valid); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr: got %h want 40", imem_addr); end
    tick; is_branch = 1'b0; #2;
    checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL br_tpc: got %h want 40", id_pc); end
    checks++; if (id_inst !== mem_f(32'h40)) begin errors++; $display("FAIL br_tinst: got %h want %h", id_inst, mem_f(32'h40)); end
    checks++; if (id_valid !== 1'b1 || flush_id !== 1'b0) begin errors++; $display("FAIL br_after: got v=%b f=%b want v=1 f=0", id_valid, flush_id); end
    checks++; if (id_pc4 !== 32'h44) begin errors++; $display("FAIL br_pc4: got %h want 44", id_pc4); end
  endtask

  task automatic test_stall;
    is_branch = 1'b1; branch_target = 32'h20;
    tick; is_branch = 1'b0; #2;
    checks++; if (id_pc !== 32'h20 || id_inst !== mem_f(32'h20)) begin errors++; $display("FAIL st_setup: got pc=%h inst=%h want pc=20 inst=%h", id_pc, id_inst, mem_f(32'h20)); end
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i != 0) tick;
      #2;
      checks++; if (id_pc !== 32'h20 || id_inst !== mem_f(32'h20) || id_valid !== 1'b1) begin errors++; $display("FAIL st_hold%0d: got pc=%h inst=%h v=%b want pc=20 inst=%h v=1", i, id_pc, id_inst, id_valid, mem_f(32'h20)); end
      checks++; if (imem_en !== 1'b0 || imem_addr !== 32'h20) begin errors++; $display("FAIL st_en%0d: got en=%b addr=%h want en=0 addr=20", i, imem_en, imem_addr); end
    end
    tick; stall = 1'b0; #2;
    checks++; if (id_pc !== 32'h20 || id_inst !== mem_f(32'h20)) begin errors++; $display("FAIL st_fall1: got pc=%h inst=%h want pc=20 inst=%h", id_pc, id_inst, mem_f(32'h20)); end
    checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL st_fall1_addr: got en=%b addr=%h want en=1 addr=24", imem_en, imem_addr); end
    tick; #2;
    checks++; if (id_pc !== 32'h24 || id_inst !== mem_f(32'h24)) begin errors++; $display("FAIL st_fall2: got pc=%h inst=%h want pc=24 inst=%h", id_pc, id_inst, mem_f(32'h24)); end
  endtask

  task automatic test_stall_branch;
    is_branch = 1'b1; branch_target = 32'h60;
    tick; is_branch = 1'b0; stall = 1'b1;
    tick; is_branch = 1'b1; branch_target = 32'h81; #2;
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL sb_addr: got %h want 80", imem_addr); end
    checks++; if (flush_id !== 1'b1 || imem_en !== 1'b1) begin errors++; $display("FAIL sb_flush: got f=%b en=%b want f=1 en=1", flush_id, imem_en); end
    tick; is_branch = 1'b0; stall = 1'b0; #2;
    checks++; if (id_pc !== 32'h80) begin errors++; $display("FAIL sb_pc: got %h want 80", id_pc); end
    checks++; if (id_inst !== mem_f(32'h80) || id_valid !== 1'b1) begin errors++; $display("FAIL sb_inst: got inst=%h v=%b want inst=%h v=1", id_inst, id_valid, mem_f(32'h80)); end
  endtask

  task automatic test_wrap;
    is_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick; is_branch = 1'b0; #2;
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_top: got pc=%h pc4=%h addr=%h want fffffffc 0 0", id_pc, id_pc4, imem_addr); end
    tick; #2;
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h13) begin errors++; $display("FAIL wr_zero: got pc=%h inst=%h want pc=0 inst=13", id_pc, id_inst); end
  endtask

  task automatic test_reset_mid;
    is_branch = 1'b1; branch_target = 32'h30;
    tick; is_branch = 1'b0; stall = 1'b1;
    tick; #2;
    rst_n = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_pc: got pc=%h addr=%h want 0 0", id_pc, imem_addr); end
    stall = 1'b0;
    tick; rst_n = 1'b1; #2;
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_c1: got v=%b addr=%h want v=0 addr=0", id_valid, imem_addr); end
    tick; #2;
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h13 || id_valid !== 1'b1) begin errors++; $display("FAIL rm_c2: got pc=%h inst=%h v=%b want 0 13 1", id_pc, id_inst, id_valid); end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_stall;
    test_stall_branch;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
